// File: rtl/prv32_muldiv_unit_if.sv
// Core-side request/response bundle for the iterative multiply/divide unit.
// The core is the master: it drives the request and samples busy/done/r.
interface prv32_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] r;

    modport master (
        output start, funct3, a, b,
        input  busy, done, r
    );

    modport slave (
        input  start, funct3, a, b,
        output busy, done, r
    );
endinterface

// File: rtl/prv32_muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Shift-add multiply and restoring
// divide on operand magnitudes, one step per clock, sign fixed up on the
// last step. Divide-by-zero and signed overflow complete on the fast path.
module prv32_muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic               clk,
    input logic               rst,
    prv32_muldiv_unit_if.slave bus
);
    localparam int CNTW = $clog2(XLEN) + 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic [2*XLEN-1:0] acc;     // product, or {remainder, dividend/quotient}
    logic [2*XLEN-1:0] mcand;   // multiplicand, shifted left each step
    logic [XLEN-1:0]   opb;     // multiplier (shifted right) or divisor
    logic [2:0]        op;
    logic              an;      // a contributes a negative sign
    logic              bn;      // b contributes a negative sign

    // Incoming request decode: operand signs, magnitudes and fast-path result
    logic              in_as;
    logic              in_bs;
    logic              in_an;
    logic              in_bn;
    logic [XLEN-1:0]   in_ma;
    logic [XLEN-1:0]   in_mb;
    logic              in_fast;
    logic [XLEN-1:0]   fast_r;

    // Decode the request presented on start
    always_comb begin
        in_as   = 1'b0;
        in_bs   = 1'b0;
        in_fast = 1'b0;
        fast_r  = '0;
        if (bus.funct3[2]) begin
            in_as = ~bus.funct3[0];
            in_bs = ~bus.funct3[0];
        end else begin
            in_as = (bus.funct3[1:0] != 2'b11);
            in_bs = ~bus.funct3[1];
        end
        in_an = in_as & bus.a[XLEN-1];
        in_bn = in_bs & bus.b[XLEN-1];
        in_ma = in_an ? ('0 - bus.a) : bus.a;
        in_mb = in_bn ? ('0 - bus.b) : bus.b;
        if (bus.funct3[2]) begin
            if (bus.b == '0) begin
                in_fast = 1'b1;
                fast_r  = bus.funct3[1] ? bus.a : '1;
            end else if (!bus.funct3[0] && bus.a == MIN_NEG && bus.b == '1) begin
                in_fast = 1'b1;
                fast_r  = bus.funct3[1] ? '0 : bus.a;
            end
        end
    end

    // One iteration plus the result that would be taken if this is the last
    logic [2*XLEN-1:0] mul_acc;
    logic [2*XLEN-1:0] div_acc;
    logic [2*XLEN-1:0] acc_nx;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     div_up;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   res;

    // Datapath step: shift-add or restoring-divide, then final sign/selection
    always_comb begin
        mul_acc = acc + (opb[0] ? mcand : '0);
        // Remainder after the left shift needs one extra bit before compare;
        // the difference itself always fits back into XLEN bits.
        div_up   = acc[2*XLEN-1:XLEN-1];
        div_diff = div_up[XLEN-1:0] - opb;
        if (div_up >= {1'b0, opb}) begin
            div_acc = {div_diff, acc[XLEN-2:0], 1'b1};
        end else begin
            div_acc = {acc[2*XLEN-2:0], 1'b0};
        end
        acc_nx = op[2] ? div_acc : mul_acc;
        prod   = (an ^ bn) ? ('0 - acc_nx) : acc_nx;
        quo    = acc_nx[XLEN-1:0];
        rem    = acc_nx[2*XLEN-1:XLEN];
        res    = '0;
        case (op)
            3'b000:         res = prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101: res = (an ^ bn) ? ('0 - quo) : quo;
            default:        res = an ? ('0 - rem) : rem;
        endcase
    end

    // Control FSM with registered busy/done/r and operand/accumulator state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            opb      <= '0;
            op       <= '0;
            an       <= 1'b0;
            bn       <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.r    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        op    <= bus.funct3;
                        an    <= in_an;
                        bn    <= in_bn;
                        cnt   <= '0;
                        opb   <= in_mb;
                        mcand <= {{XLEN{1'b0}}, in_ma};
                        acc   <= bus.funct3[2] ? {{XLEN{1'b0}}, in_ma} : '0;
                        if (in_fast) begin
                            state    <= S_DONE;
                            bus.r    <= fast_r;
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                        end else begin
                            state    <= S_RUN;
                            bus.done <= 1'b0;
                            bus.busy <= 1'b1;
                        end
                    end else begin
                        state    <= S_IDLE;
                        bus.done <= 1'b0;
                        bus.busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    cnt   <= cnt + CNTW'(1);
                    acc   <= acc_nx;
                    mcand <= {mcand[2*XLEN-2:0], 1'b0};
                    if (!op[2]) begin
                        opb <= {1'b0, opb[XLEN-1:1]};
                    end
                    if (cnt == LAST) begin
                        state    <= S_DONE;
                        bus.r    <= res;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prv32_muldiv_unit.sv
// Self-checking bench for prv32_muldiv_unit: directed RV32M corner cases,
// back-to-back issue, reset abort, then randomized ops against a model.
module tb_prv32_muldiv_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    prv32_muldiv_unit_if #(.XLEN(32)) bus ();

    prv32_muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RV32M semantics with plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                              input logic [31:0] y);
        longint            sx;
        longint            sy;
        longint            uy;
        longint unsigned   ux;
        longint unsigned   uuy;
        logic [63:0]       p;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        uy  = {32'd0, y};
        ux  = {32'd0, x};
        uuy = {32'd0, y};
        case (f)
            3'd0: begin p = sx * sy;   return p[31:0];  end
            3'd1: begin p = sx * sy;   return p[63:32]; end
            3'd2: begin p = sx * uy;   return p[63:32]; end
            3'd3: begin p = ux * uuy;  return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                p = sx / sy;
                return p[31:0];
            end
            3'd5: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                p = sx % sy;
                return p[31:0];
            end
            default: begin
                if (y == 32'd0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Issue one op at posedge+#1; junk on the request lines while running
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_r, input int exp_lat);
        int lat;
        int busyc;
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.a      = x;
        bus.b      = y;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.a      = $urandom;
        bus.b      = $urandom;
        lat   = 0;
        busyc = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) busyc++;
            bus.start  = 1'($urandom_range(0, 1));
            bus.funct3 = 3'($urandom);
            bus.a      = $urandom;
            bus.b      = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        check({tag, "_r"}, bus.r, exp_r);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busyc), 32'(exp_lat));
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] held;
        int          dcount;

        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.funct3 = 3'd0;
        bus.a      = 32'd0;
        bus.b      = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_r", bus.r, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 32);
        @(posedge clk); #1;
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_hold", bus.r, 32'hFFFF_FFFA);
        run_op("mulh_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
        run_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
        run_op("div_m7", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
        run_op("rem_m7", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
        run_op("divu_big", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32);
        @(posedge clk); #1;
        run_op("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        @(posedge clk); #1;
        run_op("remu_z", 3'd7, 32'd5, 32'd0, 32'd5, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        run_op("b2b_divu", 3'd5, 32'd100, 32'd7, 32'd14, 32);
        @(posedge clk); #1;

        // Reset aborts a running op; the held result is cleared
        held = bus.r;
        bus.start  = 1'b1;
        bus.funct3 = 3'd0;
        bus.a      = 32'd123;
        bus.b      = 32'd456;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("run_busy", 32'(bus.busy), 32'd1);
        check("run_hold", bus.r, held);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_r", bus.r, 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) dcount++;
        end
        check("abort_quiet", 32'(dcount), 32'd0);
        run_op("mul_6x7", 3'd0, 32'd6, 32'd7, 32'd42, 32);

        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom);
            x = pick_operand();
            y = pick_operand();
            if (f[2] && (y == 32'd0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
                run_op("rnd_fast", f, x, y, ref_model(f, x, y), 0);
            else
                run_op("rnd", f, x, y, ref_model(f, x, y), 32);
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/prv32_muldiv_unit.md
Name: prv32_muldiv_unit

Overview:
Iterative multiply/divide unit implementing the RV32M operations, parametrised in operand width XLEN. It sits beside the combinational ALU in the execute stage. The core stalls on busy and takes r when done pulses. Operands are latched at start, so the core may change a/b freely while the unit is busy.

Parameters:
XLEN, 32, operand/result width in bits (must be >= 4)
CNTW, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE or DONE
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  XLEN  rs1 operand
b  input  XLEN  rs2 operand
busy  output  1  high while iterating (RUN)
done  output  1  one-cycle pulse; r valid
r  output  XLEN  registered result; holds until the next done

Behaviour:
- Reset:
  - Synchronous, active-high, priority over everything.
  - State=IDLE; busy=0, done=0, r=0, counter=0.
  - Reset mid-RUN aborts the op; no done is produced.
- States:
  - IDLE: done=0, busy=0.
  - RUN: busy=1, done=0.
  - DONE: done=1, busy=0, r updated on the entry edge.
- Start acceptance:
  - start=1 at edge E0 in IDLE or DONE latches a, b, funct3 and clears the counter.
  - Fast path (below) goes to DONE; otherwise the unit goes to RUN.
  - start is ignored in RUN.
- RUN step:
  - Each edge performs one iteration and increments the counter.
  - At edge E_XLEN (XLEN edges after E0) the unit moves to DONE.
  - done is therefore high in the cycle after E_XLEN, i.e. XLEN cycles after start is sampled.
- DONE exit:
  - DONE → IDLE on the next edge unless start=1, which begins a new op (back-to-back).
- Multiply:
  - Shift-add on operand magnitudes.
  - Signedness per op: MUL/MULH signed×signed; MULHSU a signed, b unsigned; MULHU unsigned×unsigned.
  - 2·XLEN-bit product; the sign is corrected in the final step.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
- Divide:
  - Restoring divide, one quotient bit per iteration, on magnitudes.
  - Quotient sign = sign(a) XOR sign(b) for DIV.
  - Remainder sign = sign(a) for REM.
  - DIVU/REMU are unsigned.
- Fast path (DONE directly after E0, done one cycle after start):
  - Divide by zero (b=0): DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow: DIV with a=1<<(XLEN-1), b=all ones → a; REM → 0.
- Width rules:
  - All internal accumulators are 2·XLEN wide; no truncation before final selection.
  - The counter must not wrap inside RUN.
- Simultaneous events: rst and start on the same edge → rst wins; state is IDLE.
- r holds its value through IDLE/RUN until the next DONE entry.

Test Plan:
- MUL 0xFFFFFFFE × 3 (−2·3) → r=0xFFFFFFFA; MULH same operands → r=0xFFFFFFFF; done exactly 32 cycles after start; busy high for 32 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → r=0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → r=0xFFFFFFFF.
- DIV −7/2 (0xFFFFFFF9, 2) → r=0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with done one cycle after start. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, also fast path.
- Back-to-back: assert start during the DONE cycle with new operands → second result correct, no IDLE bubble. Toggle start and a/b during RUN → ignored, first result unchanged.
- Assert rst at cycle 10 of RUN → busy=0, done never pulses, r=0. A subsequent MUL 6×7 → 42.
